// File: rtl/transport_rcv.sv
// transport_rcv: parses transport packets, validates framing and checksum, and
// delivers committed 16-bit words with their command through a valid/ready FIFO.
// Optional TRANSPORT_RCV_STATS_EN adds saturating good/bad packet counters.
module transport_rcv #(
    parameter int DEPTH     = 16,
    parameter int MAX_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sending,
    input  logic [7:0]               packetIn,
    output logic [1:0]               cmdOut,
    output logic [15:0]              dataOut,
    output logic                     dataValid,
    input  logic                     dataReady,
    output logic                     pktDone,
    output logic                     pktErr,
    output logic [1:0]               errCode,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic [7:0]               goodCnt,
    output logic [7:0]               badCnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL = ONE << AW;

    typedef enum logic [2:0] {IDLE, PAY_HI, PAY_LO, CHK, DRAIN} state_t;

    state_t      state;
    logic [17:0] mem [DEPTH];
    logic [AW:0] wr_c, wr_t, rd, free_w;
    logic [1:0]  cmd, h_cmd;
    logic [5:0]  cnt, h_n;
    logic [7:0]  hi, xr;
    logic        hdr_bad, hdr_ovf, pop, trunc;

    assign h_cmd     = packetIn[7:6];
    assign h_n       = packetIn[5:0];
    assign free_w    = FULL - (wr_t - rd);
    assign hdr_bad   = h_cmd == 2'b00 || h_n == '0 || 32'(h_n) > MAX_WORDS;
    assign hdr_ovf   = 32'(free_w) < 32'(h_n);
    assign dataValid = rd != wr_c;
    assign pop       = dataValid & dataReady;
    assign trunc     = !sending && (state inside {PAY_HI, PAY_LO, CHK});
    assign fifoCount = wr_c - rd;
    assign busy      = state != IDLE;
    assign dataOut   = dataValid ? mem[rd[AW-1:0]][15:0] : '0;
    assign cmdOut    = dataValid ? mem[rd[AW-1:0]][17:16] : '0;

    // Tentative words land here; only the commit pointer exposes them to the reader.
    always_ff @(posedge clk)
        if (state == PAY_LO && sending) mem[wr_t[AW-1:0]] <= {cmd, hi, packetIn};

    // Packet parser, pointer management and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wr_c    <= '0;
            wr_t    <= '0;
            rd      <= '0;
            cmd     <= '0;
            cnt     <= '0;
            hi      <= '0;
            xr      <= '0;
            pktDone <= 1'b0;
            pktErr  <= 1'b0;
            errCode <= 2'b00;
        end else begin
            pktDone <= 1'b0;
            pktErr  <= 1'b0;
            if (pop) rd <= rd + ONE;
            if (trunc) begin
                wr_t    <= wr_c;
                pktErr  <= 1'b1;
                errCode <= 2'b10;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: if (sending) begin
                        if (hdr_bad || hdr_ovf) begin
                            pktErr  <= 1'b1;
                            errCode <= hdr_bad ? 2'b01 : 2'b11;
                            state   <= DRAIN;
                        end else begin
                            cmd   <= h_cmd;
                            cnt   <= h_n;
                            xr    <= packetIn;
                            state <= PAY_HI;
                        end
                    end
                    PAY_HI: begin
                        hi    <= packetIn;
                        xr    <= xr ^ packetIn;
                        state <= PAY_LO;
                    end
                    PAY_LO: begin
                        wr_t  <= wr_t + ONE;
                        xr    <= xr ^ packetIn;
                        cnt   <= cnt - 6'd1;
                        state <= cnt == 6'd1 ? CHK : PAY_HI;
                    end
                    CHK: begin
                        if (packetIn == xr) begin
                            wr_c    <= wr_t;
                            pktDone <= 1'b1;
                        end else begin
                            wr_t    <= wr_c;
                            pktErr  <= 1'b1;
                            errCode <= 2'b11;
                        end
                        state <= IDLE;
                    end
                    DRAIN: if (!sending) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TRANSPORT_RCV_STATS_EN
    // Saturating tallies of committed and rejected packets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            goodCnt <= '0;
            badCnt  <= '0;
        end else begin
            if (pktDone && goodCnt != 8'hFF) goodCnt <= goodCnt + 8'd1;
            if (pktErr && badCnt != 8'hFF) badCnt <= badCnt + 8'd1;
        end
    end
`else
    assign goodCnt = '0;
    assign badCnt  = '0;
`endif
endmodule

// File: tb/tb_transport_rcv.sv
// tb_transport_rcv: directed checks of transport_rcv framing, checksum, FIFO and reset behaviour.
module tb_transport_rcv;
    logic        clk = 1'b0, reset = 1'b0, sending = 1'b0, dataReady = 1'b0;
    logic [7:0]  packetIn = '0;
    logic [1:0]  cmdOut, errCode;
    logic [15:0] dataOut;
    logic        dataValid, pktDone, pktErr, busy;
    logic [4:0]  fifoCount;
    logic [7:0]  goodCnt, badCnt;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  bad_pkt [6] = '{8'h82, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC3};
    logic [17:0] exp_w;

    transport_rcv dut (
        .clk(clk), .reset(reset), .sending(sending), .packetIn(packetIn),
        .cmdOut(cmdOut), .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
        .pktDone(pktDone), .pktErr(pktErr), .errCode(errCode), .busy(busy),
        .fifoCount(fifoCount), .goodCnt(goodCnt), .badCnt(badCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        sending  = 1'b1;
        packetIn = b;
        tick();
    endtask

    // Sends header, n words base+i (MSB first) and the XOR check byte; returns at T+1.
    task automatic send_pkt(input logic [1:0] c, input int n, input logic [15:0] base);
        logic [7:0]  h, x;
        logic [15:0] w;
        h = {c, 6'(n)};
        x = h;
        put(h);
        for (int i = 0; i < n; i++) begin
            w = base + 16'(i);
            put(w[15:8]);
            put(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        put(x);
        sending = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_valid", dataValid, 0);
        check("rst_done", pktDone, 0);
        check("rst_err", pktErr, 0);
        check("rst_code", errCode, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifoCount, 0);
        check("rst_data", dataOut, 0);
        reset = 1'b1;
        tick();

        // good single-word packet with a ready consumer
        dataReady = 1'b1;
        put(8'h41); put(8'h80); put(8'h01); put(8'hC0);
        sending = 1'b0;
        check("p1_done", pktDone, 1);
        check("p1_valid", dataValid, 1);
        check("p1_cmd", cmdOut, 2'b01);
        check("p1_data", dataOut, 16'h8001);
        tick();
        check("p1_done_off", pktDone, 0);
        check("p1_empty", fifoCount, 0);
        check("p1_valid_off", dataValid, 0);

        // two-word packet with stalled consumer
        dataReady = 1'b0;
        put(8'h82); put(8'h12); put(8'h34); put(8'hAB); put(8'hCD); put(8'hC2);
        sending = 1'b0;
        check("p2_done", pktDone, 1);
        check("p2_count", fifoCount, 2);
        check("p2_cmd", cmdOut, 2'b10);
        check("p2_w0", dataOut, 16'h1234);
        tick();
        check("p2_hold", fifoCount, 2);
        dataReady = 1'b1;
        tick();
        check("p2_w1", dataOut, 16'hABCD);
        check("p2_count1", fifoCount, 1);
        tick();
        check("p2_empty", dataValid, 0);
        dataReady = 1'b0;

        // bad checksum
        for (int i = 0; i < 6; i++) begin
            put(bad_pkt[i]);
            check("bad_valid", dataValid, 0);
        end
        sending = 1'b0;
        check("bad_err", pktErr, 1);
        check("bad_code", errCode, 2'b11);
        check("bad_count", fifoCount, 0);
        check("bad_done", pktDone, 0);
        tick();
        check("bad_err_off", pktErr, 0);
        check("bad_code_hold", errCode, 2'b11);

        // truncation after one tentative word, then a good packet sees only its own word
        put(8'h42); put(8'h11); put(8'h22);
        sending = 1'b0;
        tick();
        check("tr_err", pktErr, 1);
        check("tr_code", errCode, 2'b10);
        check("tr_busy", busy, 0);
        check("tr_count", fifoCount, 0);
        send_pkt(2'b01, 1, 16'h8001);
        check("tr_next_count", fifoCount, 1);
        check("tr_next_data", dataOut, 16'h8001);
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
        check("tr_next_empty", fifoCount, 0);

        // illegal headers: N>MAX_WORDS, cmd==0, N==0
        put(8'h49);
        check("n9_err", pktErr, 1);
        check("n9_code", errCode, 2'b01);
        put(8'h55);
        check("n9_busy", busy, 1);
        check("n9_err_off", pktErr, 0);
        sending = 1'b0;
        tick();
        check("n9_idle", busy, 0);
        put(8'h01);
        check("c0_err", pktErr, 1);
        put(8'hAA);
        check("c0_busy", busy, 1);
        sending = 1'b0;
        tick();
        check("c0_idle", busy, 0);
        put(8'hC0);
        check("n0_err", pktErr, 1);
        check("n0_code", errCode, 2'b01);
        sending = 1'b0;
        tick();

        // pop and commit in the same cycle
        send_pkt(2'b10, 1, 16'h0A0B);
        tick();
        put(8'hC2); put(8'h11); put(8'h11); put(8'h22); put(8'h22);
        dataReady = 1'b1;
        put(8'hC2);
        dataReady = 1'b0;
        sending = 1'b0;
        check("pc_done", pktDone, 1);
        check("pc_count", fifoCount, 2);
        check("pc_w0", {cmdOut, dataOut}, {2'b11, 16'h1111});
        dataReady = 1'b1;
        tick();
        check("pc_w1", dataOut, 16'h2222);
        tick();
        check("pc_empty", fifoCount, 0);
        dataReady = 1'b0;

        // overflow with 12 held words, then an exact fit up to full
        send_pkt(2'b01, 6, 16'h1000);
        send_pkt(2'b10, 6, 16'h2000);
        check("ov_held", fifoCount, 12);
        put(8'h45);
        check("ov_err", pktErr, 1);
        check("ov_code", errCode, 2'b11);
        for (int i = 0; i < 11; i++) put(8'h00);
        check("ov_drain_busy", busy, 1);
        sending = 1'b0;
        tick();
        check("ov_idle", busy, 0);
        check("ov_count", fifoCount, 12);
        send_pkt(2'b11, 4, 16'h3000);
        check("full_done", pktDone, 1);
        check("full_count", fifoCount, 16);
        dataReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_w = i < 6 ? {2'b01, 16'h1000 + 16'(i)} :
                    i < 12 ? {2'b10, 16'h2000 + 16'(i - 6)} : {2'b11, 16'h3000 + 16'(i - 12)};
            check("full_word", {cmdOut, dataOut}, exp_w);
            tick();
        end
        check("full_empty", dataValid, 0);
        dataReady = 1'b0;

        // async reset mid-PAY_LO with a committed word present
        send_pkt(2'b01, 1, 16'h5555);
        put(8'h42); put(8'h11);
        #2 reset = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_count", fifoCount, 0);
        check("ar_valid", dataValid, 0);
        check("ar_code", errCode, 0);
        check("ar_data", dataOut, 0);
        sending = 1'b0;
        #2 reset = 1'b1;
        tick();
        send_pkt(2'b10, 1, 16'hBEEF);
        check("ar_next_done", pktDone, 1);
        check("ar_next_count", fifoCount, 1);
        check("ar_next_word", {cmdOut, dataOut}, {2'b10, 16'hBEEF});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
